// File: rtl/vnu_pkg.sv
// Shared constants for the sign-magnitude / two's complement stream converter.
package vnu_pkg;

    localparam logic MODE_SM2TC = 1'b0;
    localparam logic MODE_TC2SM = 1'b1;

endpackage

// File: rtl/sm_tc_lane.sv
// Single-word converter between sign-magnitude and two's complement.
module sm_tc_lane
    import vnu_pkg::*;
#(
    parameter int DATA_WIDTH = 6
) (
    input  logic [DATA_WIDTH-1:0] in_word,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] out_word,
    output logic                  sat
);

    localparam int MW = DATA_WIDTH - 1;

    logic          sign;
    logic [MW-1:0] mag;

    always_comb begin
        sign     = in_word[DATA_WIDTH-1];
        mag      = in_word[MW-1:0];
        out_word = in_word;
        sat      = 1'b0;
        if (sign) begin
            if (mode == MODE_SM2TC) begin
                out_word = -{1'b0, mag};
            end else if (mag == '0) begin
                // most-negative code has no SM magnitude; clamp to max
                out_word = '1;
                sat      = 1'b1;
            end else begin
                out_word = {1'b1, -mag};
            end
        end
    end

endmodule

// File: rtl/sm_tc_stream_conv.sv
// Two-stage valid/ready pipeline converting NUM_CH words per beat
// between sign-magnitude and two's complement, with a saturation counter.
module sm_tc_stream_conv
    import vnu_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_CH     = 4,
    parameter int SAT_CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_mode,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]            out_sat,
    input  logic                         sat_clr,
    output logic [SAT_CNT_W-1:0]         sat_count
);

    localparam int BW = NUM_CH * DATA_WIDTH;

    logic                 v1_q, v1_d;
    logic                 mode1_q, mode1_d;
    logic [BW-1:0]        data1_q, data1_d;
    logic                 v2_q, v2_d;
    logic [BW-1:0]        data2_q, data2_d;
    logic [NUM_CH-1:0]    sat2_q, sat2_d;
    logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;

    logic [BW-1:0]        conv_data;
    logic [NUM_CH-1:0]    conv_sat;
    logic                 ready1, ready2;
    logic [SAT_CNT_W:0]   sum;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        sm_tc_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .in_word (data1_q[k*DATA_WIDTH +: DATA_WIDTH]),
            .mode    (mode1_q),
            .out_word(conv_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .sat     (conv_sat[k])
        );
    end

    always_comb begin
        ready2  = !v2_q || out_ready;
        ready1  = !v1_q || ready2;
        v1_d    = v1_q;
        mode1_d = mode1_q;
        data1_d = data1_q;
        v2_d    = v2_q;
        data2_d = data2_q;
        sat2_d  = sat2_q;
        if (ready1) begin
            v1_d = in_valid;
            if (in_valid) begin
                data1_d = in_data;
                mode1_d = in_mode;
            end
        end
        if (ready2) begin
            v2_d = v1_q;
            if (v1_q) begin
                data2_d = conv_data;
                sat2_d  = conv_sat;
            end
        end
    end

    always_comb begin
        sum = {1'b0, sat_count_q};
        for (int k = 0; k < NUM_CH; k++) begin
            sum = sum + {{SAT_CNT_W{1'b0}}, sat2_q[k]};
        end
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (v2_q && out_ready) begin
            sat_count_d = sum[SAT_CNT_W] ? '1 : sum[SAT_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            mode1_q     <= MODE_SM2TC;
            data1_q     <= '0;
            v2_q        <= 1'b0;
            data2_q     <= '0;
            sat2_q      <= '0;
            sat_count_q <= '0;
        end else begin
            v1_q        <= v1_d;
            mode1_q     <= mode1_d;
            data1_q     <= data1_d;
            v2_q        <= v2_d;
            data2_q     <= data2_d;
            sat2_q      <= sat2_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign in_ready  = ready1;
    assign out_valid = v2_q;
    assign out_data  = data2_q;
    assign out_sat   = sat2_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_sm_tc_stream_conv.sv
// Directed self-checking bench for sm_tc_stream_conv at 6-bit words, 4 lanes.
module tb_sm_tc_stream_conv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [23:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
    logic [3:0]  out_sat;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_count;

    int errors = 0;
    int checks = 0;

    sm_tc_stream_conv #(
        .DATA_WIDTH(6),
        .NUM_CH    (4),
        .SAT_CNT_W (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .sat_clr  (sat_clr),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    // reference: returns {sat, word} from the arithmetic meaning of the code
    function automatic logic [6:0] ref_conv(input logic m, input logic [5:0] w);
        int v;
        if (m == 1'b0) begin
            v = w[5] ? -int'(w[4:0]) : int'(w[4:0]);
            return {1'b0, 6'(v)};
        end
        v = w[5] ? int'(w) - 64 : int'(w);
        if (v == -32) return {1'b1, 6'b111111};
        if (v < 0) return {2'b01, 5'(-v)};
        return {1'b0, 6'(v)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || sat_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state valid=%b cnt=%0d want 0/0", out_valid, sat_count);
        end
        checks++;
        if (out_data !== 24'd0 || out_sat !== 4'd0) begin
            errors++;
            $display("FAIL reset_data data=%h sat=%h want 0/0", out_data, out_sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_sweep();
        logic [5:0] w;
        logic [6:0] r;
        out_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 64; c++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_mode = 1'(m);
                for (int k = 0; k < 4; k++) in_data[k*6 +: 6] = 6'(c + k);
                @(negedge clk);
                in_valid = 1'b0;
                @(negedge clk);
                #1;
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_latency m=%0d c=%0d valid=%b want 1", m, c, out_valid);
                end
                for (int k = 0; k < 4; k++) begin
                    w = 6'(c + k);
                    r = ref_conv(1'(m), w);
                    checks++;
                    if (out_data[k*6 +: 6] !== r[5:0] || out_sat[k] !== r[6]) begin
                        errors++;
                        $display("FAIL sweep m=%0d in=%b got=%b/%b want=%b/%b", m, w,
                                 out_data[k*6 +: 6], out_sat[k], r[5:0], r[6]);
                    end
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || sat_count !== 16'd4) begin
            errors++;
            $display("FAIL sweep_count valid=%b cnt=%0d want 0/4", out_valid, sat_count);
        end
    endtask

    task automatic test_boundaries();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode = 1'b0;
        in_data = {6'b100000, 6'b100000, 6'b100001, 6'b011111};
        @(negedge clk);
        in_mode = 1'b1;
        in_data = {6'b100000, 6'b000000, 6'b111111, 6'b011111};
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_data !== {6'b000000, 6'b000000, 6'b111111, 6'b011111} || out_sat !== 4'b0000) begin
            errors++;
            $display("FAIL bound_sm2tc got=%h/%b want=%h/0000", out_data, out_sat,
                     {6'b000000, 6'b000000, 6'b111111, 6'b011111});
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_data !== {6'b111111, 6'b000000, 6'b100001, 6'b011111} || out_sat !== 4'b1000) begin
            errors++;
            $display("FAIL bound_tc2sm got=%h/%b want=%h/1000", out_data, out_sat,
                     {6'b111111, 6'b000000, 6'b100001, 6'b011111});
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic [23:0] bd [8];
        logic        bm [8];
        logic [23:0] ed [8];
        logic [3:0]  es [8];
        logic [6:0]  r;
        logic [23:0] held_d;
        logic [3:0]  held_s;
        logic        stalled;
        logic        exp_rdy;
        int          tx, rx, cyc;
        for (int i = 0; i < 8; i++) begin
            bm[i] = 1'(i);
            for (int k = 0; k < 4; k++) begin
                bd[i][k*6 +: 6] = 6'(i * 7 + k * 13 + 29);
                r = ref_conv(bm[i], bd[i][k*6 +: 6]);
                ed[i][k*6 +: 6] = r[5:0];
                es[i][k] = r[6];
            end
        end
        tx = 0;
        rx = 0;
        cyc = 0;
        stalled = 1'b0;
        held_d = '0;
        held_s = '0;
        while (rx < 8 && cyc < 200) begin
            @(negedge clk);
            in_valid = (tx < 8);
            if (tx < 8) begin
                in_data = bd[tx];
                in_mode = bm[tx];
            end
            out_ready = (cyc % 3 == 0);
            #1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_sat !== held_s) begin
                    errors++;
                    $display("FAIL bp_hold got=%b/%h want=1/%h", out_valid, out_data, held_d);
                end
            end
            exp_rdy = !((tx - rx) == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== ed[rx] || out_sat !== es[rx]) begin
                    errors++;
                    $display("FAIL bp_order beat=%0d got=%h/%b want=%h/%b", rx, out_data,
                             out_sat, ed[rx], es[rx]);
                end
                rx++;
            end
            stalled = out_valid && !out_ready;
            held_d = out_data;
            held_s = out_sat;
            if (in_valid && in_ready) tx++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rx != 8) begin
            errors++;
            $display("FAIL bp_complete got=%0d beats want 8", rx);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_mode_interleave();
        logic [23:0] e_sm;
        logic [23:0] e_tc;
        logic        ev;
        e_sm = {6'b111011, 6'b111011, 6'b000000, 6'b111011};
        e_tc = {6'b111011, 6'b111011, 6'b111111, 6'b111011};
        out_ready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            in_valid = (t < 6);
            in_mode = 1'(t);
            in_data = {6'b100101, 6'b100101, 6'b100000, 6'b100101};
            #1;
            ev = (t >= 2 && t <= 7);
            checks++;
            if (out_valid !== ev) begin
                errors++;
                $display("FAIL mix_valid t=%0d got=%b want=%b", t, out_valid, ev);
            end
            if (ev) begin
                checks++;
                if (t % 2 == 0 && (out_data !== e_sm || out_sat !== 4'b0000)) begin
                    errors++;
                    $display("FAIL mix_sm2tc t=%0d got=%h/%b want=%h/0000", t, out_data,
                             out_sat, e_sm);
                end
                if (t % 2 == 1 && (out_data !== e_tc || out_sat !== 4'b0010)) begin
                    errors++;
                    $display("FAIL mix_tc2sm t=%0d got=%h/%b want=%h/0010", t, out_data,
                             out_sat, e_tc);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_sat_count();
        out_ready = 1'b1;
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        #1;
        checks++;
        if (sat_count !== 16'd0) begin
            errors++;
            $display("FAIL sat_clr_idle cnt=%0d want 0", sat_count);
        end
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            in_valid = (t < 3);
            in_mode = 1'b1;
            in_data = {4{6'b100000}};
            #1;
            if (out_valid) begin
                checks++;
                if (out_sat !== 4'hF || out_data !== {4{6'b111111}}) begin
                    errors++;
                    $display("FAIL sat_flags got=%h/%b want=fff/1111", out_data, out_sat);
                end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sat_count !== 16'd12) begin
            errors++;
            $display("FAIL sat_count got=%0d want 12", sat_count);
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        sat_clr = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_sat !== 4'hF) begin
            errors++;
            $display("FAIL sat_fourth valid=%b sat=%b want 1/1111", out_valid, out_sat);
        end
        @(negedge clk);
        sat_clr = 1'b0;
        #1;
        checks++;
        if (sat_count !== 16'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_clr_wins cnt=%0d valid=%b want 0/0", sat_count, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode = 1'b1;
        in_data = {6'b000001, 6'b100000, 6'b000001, 6'b000001};
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sat_count !== 16'd1) begin
            errors++;
            $display("FAIL rst_pre_count cnt=%0d want 1", sat_count);
        end
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = {4{6'b010101}};
        @(negedge clk);
        in_data = {4{6'b001100}};
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_full ready=%b valid=%b want 0/1", in_ready, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sat_count !== 16'd0 || out_data !== 24'd0) begin
            errors++;
            $display("FAIL rst_async valid=%b cnt=%0d data=%h want 0/0/0", out_valid,
                     sat_count, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready in_ready=%b want 1", in_ready);
        end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale t=%0d out_valid=%b want 0", t, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_boundaries();
        test_back_pressure();
        test_mode_interleave();
        test_sat_count();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
